muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RISC-V M-extension multiply/divide unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package muldiv_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Funct3 encodings of the M-extension operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    // Funct7 value that selects the M-extension
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between an issuing core and the multiply/divide unit.
// Latency: n/a (wires only).
// Backpressure: start is honoured only while busy is low; it is dropped otherwise.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [6:0]       Funct7;
    logic [2:0]       Funct3;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;

    // Issuing side
    modport master (
        output start, Funct7, Funct3, SrcA, SrcB,
        input  busy, done, Result
    );

    // Execution unit side
    modport slave (
        input  start, Funct7, Funct3, SrcA, SrcB,
        output busy, done, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide, shared accumulator.
// Latency: WIDTH+1 edges from accept to done for normal ops, 1 edge for divide-by-zero/overflow.
// Backpressure: busy high outside IDLE; start during busy or with a foreign Funct7 is ignored.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    muldiv_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ZERO_W   = '0;

    state_t             state, state_nxt;
    op_t                op;
    logic               neg;
    logic               special;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;

    // Request decode in IDLE
    logic               accept;
    logic               a_signed, b_signed;
    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               div0, ovf, special_in;
    logic [WIDTH-1:0]   special_val;
    logic               neg_in;

    // Step and result datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   res_sel;

    assign accept = bus.start && (bus.Funct7 == FUNCT7_MULDIV);
    assign bus.busy = (state != IDLE);

    // Decode operand signedness, special divide cases and the result-negate flag
    always_comb begin
        a_signed    = 1'b0;
        b_signed    = 1'b0;
        neg_in      = 1'b0;
        special_val = '0;
        unique case (op_t'(bus.Funct3))
            OP_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; end
            OP_MULHSU: begin a_signed = 1'b1; end
            OP_DIV:    begin a_signed = 1'b1; b_signed = 1'b1; end
            OP_REM:    begin a_signed = 1'b1; b_signed = 1'b1; end
            default:   begin end
        endcase
        sa    = a_signed & bus.SrcA[WIDTH-1];
        sb    = b_signed & bus.SrcB[WIDTH-1];
        abs_a = sa ? (ZERO_W - bus.SrcA) : bus.SrcA;
        abs_b = sb ? (ZERO_W - bus.SrcB) : bus.SrcB;
        // Remainders follow the dividend sign, everything else the product/quotient sign
        if (op_t'(bus.Funct3) == OP_MULHSU || op_t'(bus.Funct3) == OP_REM)
            neg_in = sa;
        else
            neg_in = sa ^ sb;
        div0 = bus.Funct3[2] && (bus.SrcB == ZERO_W);
        ovf  = bus.Funct3[2] && !bus.Funct3[0] &&
               (bus.SrcA == MOST_NEG) && (bus.SrcB == {WIDTH{1'b1}});
        special_in = div0 | ovf;
        if (div0)
            special_val = bus.Funct3[1] ? bus.SrcA : {WIDTH{1'b1}};
        else if (ovf)
            special_val = bus.Funct3[1] ? ZERO_W : MOST_NEG;
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
        acc_step  = acc;
        if (op[2]) begin
            if (!div_trial[WIDTH])
                acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_step = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    // Select and sign-correct the final result from the accumulator
    always_comb begin
        prod_neg = {(2*WIDTH){1'b0}} - acc;
        quo      = acc[WIDTH-1:0];
        rem      = acc[2*WIDTH-1:WIDTH];
        res_sel  = '0;
        if (special) begin
            res_sel = acc[WIDTH-1:0];
        end else begin
            unique case (op)
                OP_MUL:                     res_sel = acc[WIDTH-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU:
                    res_sel = neg ? prod_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                OP_DIV, OP_DIVU:            res_sel = neg ? (ZERO_W - quo) : quo;
                OP_REM, OP_REMU:            res_sel = neg ? (ZERO_W - rem) : rem;
                default:                    res_sel = '0;
            endcase
        end
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Controller next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = special_in ? DONE : CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration and result/done registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op         <= OP_MUL;
            neg        <= 1'b0;
            special    <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            opb        <= '0;
            bus.done   <= 1'b0;
            bus.Result <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op      <= op_t'(bus.Funct3);
                        neg     <= neg_in;
                        special <= special_in;
                        cnt     <= CW'(WIDTH-1);
                        opb     <= abs_b;
                        acc     <= {ZERO_W, special_in ? special_val : abs_a};
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - 1'b1;
                end
                DONE: begin
                    bus.Result <= res_sel;
                    bus.done   <= 1'b1;
                end
                default: begin end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request for one cycle; returns after the accepting edge (+1)
    task automatic launch(input logic [6:0] f7, input logic [2:0] f3,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.Funct7 = f7;
        bus.Funct3 = f3;
        bus.SrcA   = a;
        bus.SrcB   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Run one operation, checking result, done latency, busy length and single-cycle done.
    // poke > 0 injects a stray start with different operands that many edges after accept.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int exp_lat, input int poke);
        int edges;
        int busy_cnt;
        launch(FUNCT7_MULDIV, f3, a, b);
        edges    = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && edges < 200) begin
            if (poke > 0 && edges == poke) begin
                bus.start  = 1'b1;
                bus.Funct3 = OP_DIVU;
                bus.SrcA   = 32'h0000_0064;
                bus.SrcB   = 32'h0000_0007;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            edges++;
            if (bus.busy) busy_cnt++;
        end
        check({tag, " result"}, 64'(bus.Result), 64'(exp));
        check({tag, " latency"}, 64'(edges), 64'(exp_lat));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, " result_hold"}, 64'(bus.Result), 64'(exp));
    endtask

    initial begin
        int seen_busy;
        int seen_done;
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.Funct7 = '0;
        bus.Funct3 = '0;
        bus.SrcA   = '0;
        bus.SrcB   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset result", 64'(bus.Result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply family
        run_op("mul",      OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, W+1, 0);
        run_op("mulh",     OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, W+1, 0);
        run_op("mulhu",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, W+1, 0);
        run_op("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, W+1, 0);
        run_op("mul_lo0",  OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, W+1, 0);
        run_op("mulhu_1",  OP_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, W+1, 0);

        // Divide family
        run_op("div",      OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, W+1, 0);
        run_op("rem",      OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, W+1, 0);
        run_op("divu",     OP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, W+1, 0);
        run_op("remu",     OP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, W+1, 0);
        run_op("div_nb",   OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, W+1, 0);
        run_op("rem_nb",   OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, W+1, 0);
        run_op("divu_max", OP_DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, W+1, 0);

        // Special cases bypass the iteration
        run_op("div_by0",  OP_DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1, 0);
        run_op("remu_by0", OP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1, 0);
        run_op("divu_by0", OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1, 0);
        run_op("div_ovf",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);

        // Stray start while busy must not disturb the multiply in flight
        run_op("mul_poke", OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, W+1, 10);

        // Foreign Funct7 is ignored
        launch(7'b0000000, OP_MUL, 32'h0000_0003, 32'h0000_0004);
        seen_busy = bus.busy ? 1 : 0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) seen_busy++;
            if (bus.done) seen_done++;
        end
        check("f7_ignored busy", 64'(seen_busy), 64'd0);
        check("f7_ignored done", 64'(seen_done), 64'd0);
        check("f7_ignored result", 64'(bus.Result), 64'hFFFF_FFEB);

        // Reset in the middle of a divide aborts it
        launch(FUNCT7_MULDIV, OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        repeat (15) @(posedge clk);
        #2;
        check("abort busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort result", 64'(bus.Result), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        check("abort no_done", 64'(seen_done), 64'd0);
        run_op("mul_after_rst", OP_MUL, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C, W+1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
